fnd_scan_decoder: RTL and testbench

FND_SCAN_DECODER -- requirements
Module: fnd_scan_decoder

---
 rtl/fnd_pkg.sv | 46 ++++
 rtl/fnd_font_decoder.sv | 29 ++
 rtl/fnd_scan_decoder.sv | 169 ++++++++++++++++
 tb/tb_fnd_scan_decoder.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/fnd_pkg.sv
// Shared definitions for the FND scan decoder: segment fonts, digit select codes,
// FSM states and helper functions.
package fnd_pkg;

  localparam logic [7:0] FONT_0 = 8'hC0;
  localparam logic [7:0] FONT_1 = 8'hF9;
  localparam logic [7:0] FONT_2 = 8'hA4;
  localparam logic [7:0] FONT_3 = 8'hB0;
  localparam logic [7:0] FONT_4 = 8'h99;
  localparam logic [7:0] FONT_5 = 8'h92;
  localparam logic [7:0] FONT_6 = 8'h82;
  localparam logic [7:0] FONT_7 = 8'hF8;
  localparam logic [7:0] FONT_8 = 8'h80;
  localparam logic [7:0] FONT_9 = 8'h90;

  localparam logic [3:0] SEL_ONES      = 4'b1110;
  localparam logic [3:0] SEL_TENS      = 4'b1101;
  localparam logic [3:0] SEL_HUNDREDS  = 4'b1011;
  localparam logic [3:0] SEL_THOUSANDS = 4'b0111;

  typedef enum logic [1:0] {WAIT_SEL, SETTLE, HOLD, COMPUTE} state_t;

  typedef logic [3:0] bcd_t;

  function automatic logic isSelValid(input logic [3:0] sel);
    return (sel == SEL_ONES) || (sel == SEL_TENS) ||
           (sel == SEL_HUNDREDS) || (sel == SEL_THOUSANDS);
  endfunction

  function automatic logic [1:0] selToSlot(input logic [3:0] sel);
    logic [1:0] slot;
    case (sel)
      SEL_TENS:      slot = 2'd1;
      SEL_HUNDREDS:  slot = 2'd2;
      SEL_THOUSANDS: slot = 2'd3;
      default:       slot = 2'd0;
    endcase
    return slot;
  endfunction

  function automatic logic [13:0] bcdToValue(input bcd_t d3, input bcd_t d2,
                                             input bcd_t d1, input bcd_t d0);
    return 14'(d3) * 14'd1000 + 14'(d2) * 14'd100 + 14'(d1) * 14'd10 + 14'(d0);
  endfunction

endpackage

// File: rtl/fnd_font_decoder.sv
// Combinational 7-segment font to BCD decoder; the decimal point is not an input,
// so only the seven active-low segment bits take part in the lookup.
module fnd_font_decoder
  import fnd_pkg::*;
(
  input  logic [6:0] i_segments,
  output bcd_t       o_bcd,
  output logic       o_valid
);

  always_comb begin
    o_bcd   = '0;
    o_valid = 1'b1;
    case (i_segments)
      FONT_0[6:0]: o_bcd = 4'd0;
      FONT_1[6:0]: o_bcd = 4'd1;
      FONT_2[6:0]: o_bcd = 4'd2;
      FONT_3[6:0]: o_bcd = 4'd3;
      FONT_4[6:0]: o_bcd = 4'd4;
      FONT_5[6:0]: o_bcd = 4'd5;
      FONT_6[6:0]: o_bcd = 4'd6;
      FONT_7[6:0]: o_bcd = 4'd7;
      FONT_8[6:0]: o_bcd = 4'd8;
      FONT_9[6:0]: o_bcd = 4'd9;
      default:     o_valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/fnd_scan_decoder.sv
// Recovers the decimal value shown on a scanned 4-digit FND by snooping its select
// and font lines. Define FND_SCAN_DP_EN to also capture the decimal points on o_dp.
module fnd_scan_decoder
  import fnd_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [3:0]  i_digitSelect,
  input  logic [7:0]  i_fndFont,
  output logic [13:0] o_value,
  output logic        o_valid,
  output logic        o_error
`ifdef FND_SCAN_DP_EN
  ,
  output logic [3:0]  o_dp
`endif
);

  localparam logic [7:0] STABLE_LIM = 8'(STABLE_CYCLES);

  state_t      r_state;
  state_t      w_stateNext;
  logic [7:0]  r_cnt;
  logic [7:0]  w_cntNext;
  logic [7:0]  w_cntInc;
  logic [3:0]  r_prevSel;
  logic [7:0]  r_prevFont;
  logic [3:0]  r_capSel;
  logic [3:0]  r_seen;
  bcd_t        r_digits [4];
  logic [13:0] r_value;
  logic        r_valid;
  logic        r_error;
  logic [7:0]  w_fontMasked;
  logic        w_selOk;
  logic        w_same;
  logic        w_capture;
  logic [3:0]  w_slotBit;
  logic [1:0]  w_slot;
  bcd_t        w_bcd;
  logic        w_fontValid;

  // Without the dp feature bit 7 must not even count as a font change.
`ifdef FND_SCAN_DP_EN
  logic [3:0]  r_dpSlot;
  logic [3:0]  r_dp;
  assign w_fontMasked = i_fndFont;
  assign o_dp         = r_dp;
`else
  logic        w_unusedDp;
  assign w_unusedDp   = i_fndFont[7];
  assign w_fontMasked = {1'b0, i_fndFont[6:0]};
`endif

  assign w_selOk   = isSelValid(i_digitSelect);
  assign w_same    = (i_digitSelect == r_prevSel) && (w_fontMasked == r_prevFont);
  assign w_cntInc  = r_cnt + 8'd1;
  assign w_slotBit = ~i_digitSelect;
  assign w_slot    = selToSlot(i_digitSelect);

  fnd_font_decoder u_fontDecoder (
    .i_segments (i_fndFont[6:0]),
    .o_bcd      (w_bcd),
    .o_valid    (w_fontValid)
  );

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) r_state <= WAIT_SEL;
    else          r_state <= w_stateNext;
  end

  always_comb begin
    w_stateNext = r_state;
    w_cntNext   = r_cnt;
    w_capture   = 1'b0;
    case (r_state)
      WAIT_SEL: begin
        if (w_selOk) begin
          w_cntNext   = 8'd1;
          w_stateNext = SETTLE;
        end else begin
          w_cntNext   = 8'd0;
        end
      end
      SETTLE: begin
        if (!w_selOk) begin
          w_cntNext   = 8'd0;
          w_stateNext = WAIT_SEL;
        end else if (!w_same) begin
          w_cntNext   = 8'd1;
        end else if (w_cntInc >= STABLE_LIM) begin
          w_capture   = 1'b1;
          w_cntNext   = 8'd0;
          w_stateNext = (w_fontValid && ((r_seen | w_slotBit) == 4'hF)) ? COMPUTE : HOLD;
        end else begin
          w_cntNext   = w_cntInc;
        end
      end
      HOLD: begin
        // Only a new select restarts acquisition; font flicker on the held digit is ignored.
        if (i_digitSelect != r_capSel) begin
          if (w_selOk) begin
            w_cntNext   = 8'd1;
            w_stateNext = SETTLE;
          end else begin
            w_cntNext   = 8'd0;
            w_stateNext = WAIT_SEL;
          end
        end
      end
      COMPUTE: begin
        w_stateNext = HOLD;
      end
      default: w_stateNext = WAIT_SEL;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_cnt      <= '0;
      r_prevSel  <= 4'hF;
      r_prevFont <= '0;
      r_capSel   <= 4'hF;
      r_seen     <= '0;
      r_digits   <= '{default: '0};
      r_value    <= '0;
      r_valid    <= 1'b0;
      r_error    <= 1'b0;
`ifdef FND_SCAN_DP_EN
      r_dpSlot   <= '0;
      r_dp       <= '0;
`endif
    end else begin
      r_cnt      <= w_cntNext;
      r_prevSel  <= i_digitSelect;
      r_prevFont <= w_fontMasked;
      r_valid    <= 1'b0;
      r_error    <= 1'b0;
      if (w_capture) begin
        r_capSel <= i_digitSelect;
        if (w_fontValid) begin
          r_digits[w_slot] <= w_bcd;
          r_seen           <= r_seen | w_slotBit;
`ifdef FND_SCAN_DP_EN
          r_dpSlot[w_slot] <= ~i_fndFont[7];
`endif
        end else begin
          r_seen  <= '0;
          r_error <= 1'b1;
        end
      end
      if (r_state == COMPUTE) begin
        r_value <= bcdToValue(r_digits[3], r_digits[2], r_digits[1], r_digits[0]);
        r_valid <= 1'b1;
        r_seen  <= '0;
`ifdef FND_SCAN_DP_EN
        r_dp    <= r_dpSlot;
`endif
      end
    end
  end

  assign o_value = r_value;
  assign o_valid = r_valid;
  assign o_error = r_error;

endmodule

// File: tb/tb_fnd_scan_decoder.sv
// Directed self-checking bench for fnd_scan_decoder (STABLE_CYCLES = 4); inputs change
// and outputs are sampled on the falling clock edge.
module tb_fnd_scan_decoder;

  logic        clk = 1'b0;
  logic        rstN;
  logic [3:0]  digitSelect;
  logic [7:0]  fndFont;
  logic [13:0] value;
  logic        valid;
  logic        error;
`ifdef FND_SCAN_DP_EN
  logic [3:0]  dp;
`endif

  int checkCount = 0;
  int errCount = 0;
  int validPulses = 0;
  int errorPulses = 0;
  int overlapCount = 0;
  int validBefore;
  int errorBefore;

  always #5 clk = ~clk;

  fnd_scan_decoder #(.STABLE_CYCLES(4)) dut (
    .i_clk         (clk),
    .i_reset       (rstN),
    .i_digitSelect (digitSelect),
    .i_fndFont     (fndFont),
    .o_value       (value),
    .o_valid       (valid),
    .o_error       (error)
`ifdef FND_SCAN_DP_EN
    ,
    .o_dp          (dp)
`endif
  );

  always @(negedge clk) begin
    if (valid === 1'b1) validPulses++;
    if (error === 1'b1) errorPulses++;
    if (valid === 1'b1 && error === 1'b1) overlapCount++;
  end

  task automatic applyStimulus(input logic [3:0] sel, input logic [7:0] font, input int cycles);
    digitSelect = sel;
    fndFont     = font;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) else begin
      errCount++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  initial begin
    rstN        = 1'b0;
    digitSelect = 4'b1111;
    fndFont     = 8'hFF;
    repeat (3) @(negedge clk);
    checkOutput("resetValue", 32'(value), 32'd0);
    checkOutput("resetValid", 32'(valid), 32'd0);
    checkOutput("resetError", 32'(error), 32'd0);
    rstN = 1'b1;
    applyStimulus(4'b1111, 8'hFF, 3);

    $display("[TB] scan 1234");
    applyStimulus(4'b1110, 8'h99, 10);
    applyStimulus(4'b1101, 8'hB0, 10);
    applyStimulus(4'b1011, 8'hA4, 10);
    applyStimulus(4'b0111, 8'hF9, 4);
    checkOutput("validNotEarly", 32'(valid), 32'd0);
    applyStimulus(4'b0111, 8'hF9, 1);
    checkOutput("validLatency", 32'(valid), 32'd1);
    checkOutput("value1234", 32'(value), 32'd1234);
    applyStimulus(4'b0111, 8'hF9, 5);
    applyStimulus(4'b1111, 8'hFF, 5);
    checkOutput("value1234Held", 32'(value), 32'd1234);
    checkOutput("pulses1234", 32'(validPulses), 32'd1);
    checkOutput("noError1234", 32'(errorPulses), 32'd0);

    $display("[TB] unstable select");
    validBefore = validPulses;
    for (int r = 0; r < 2; r++) begin
      applyStimulus(4'b1110, 8'h92, 3);
      applyStimulus(4'b1101, 8'h82, 3);
      applyStimulus(4'b1011, 8'hF8, 3);
      applyStimulus(4'b0111, 8'h80, 3);
    end
    applyStimulus(4'b1111, 8'hFF, 5);
    checkOutput("unstableNoValid", 32'(validPulses - validBefore), 32'd0);
    checkOutput("unstableNoError", 32'(errorPulses), 32'd0);

    $display("[TB] invalid tens font");
    validBefore = validPulses;
    errorBefore = errorPulses;
    applyStimulus(4'b1110, 8'h99, 10);
    applyStimulus(4'b1101, 8'hFF, 4);
    checkOutput("errorPulse", 32'(error), 32'd1);
    applyStimulus(4'b1101, 8'hFF, 1);
    checkOutput("errorOneCycle", 32'(error), 32'd0);
    applyStimulus(4'b1101, 8'hFF, 5);
    applyStimulus(4'b1111, 8'hFF, 5);
    checkOutput("errorCount", 32'(errorPulses - errorBefore), 32'd1);
    checkOutput("errorNoValid", 32'(validPulses - validBefore), 32'd0);
    checkOutput("valueAfterError", 32'(value), 32'd1234);

    $display("[TB] scan 0567");
    validBefore = validPulses;
    applyStimulus(4'b1110, 8'hF8, 10);
    applyStimulus(4'b1101, 8'h82, 10);
    applyStimulus(4'b1011, 8'h92, 10);
    applyStimulus(4'b0111, 8'hC0, 10);
    applyStimulus(4'b1111, 8'hFF, 5);
    checkOutput("value0567", 32'(value), 32'd567);
    checkOutput("pulses0567", 32'(validPulses - validBefore), 32'd1);

    $display("[TB] reset mid-frame");
    applyStimulus(4'b1110, 8'h82, 10);
    applyStimulus(4'b1101, 8'hF8, 10);
    applyStimulus(4'b1011, 8'h80, 2);
    rstN = 1'b0;
    applyStimulus(4'b1111, 8'hFF, 3);
    checkOutput("midResetValue", 32'(value), 32'd0);
    checkOutput("midResetValid", 32'(valid), 32'd0);
    checkOutput("midResetError", 32'(error), 32'd0);
    rstN = 1'b1;
    applyStimulus(4'b1111, 8'hFF, 3);
    validBefore = validPulses;
    applyStimulus(4'b1110, 8'hF9, 10);
    applyStimulus(4'b1101, 8'hA4, 10);
    applyStimulus(4'b1011, 8'hB0, 10);
    checkOutput("partialNoValid", 32'(validPulses - validBefore), 32'd0);
    applyStimulus(4'b0111, 8'h99, 10);
    applyStimulus(4'b1111, 8'hFF, 5);
    checkOutput("value4321", 32'(value), 32'd4321);
    checkOutput("pulses4321", 32'(validPulses - validBefore), 32'd1);

    $display("[TB] scan 9999 with idle gaps");
    validBefore = validPulses;
    applyStimulus(4'b1111, 8'hFF, 3);
    applyStimulus(4'b1110, 8'h90, 10);
    applyStimulus(4'b1111, 8'hFF, 3);
    applyStimulus(4'b1101, 8'h90, 10);
    applyStimulus(4'b1111, 8'hFF, 3);
    applyStimulus(4'b1011, 8'h10, 10);
    applyStimulus(4'b1111, 8'hFF, 3);
    applyStimulus(4'b0111, 8'h90, 10);
    applyStimulus(4'b1111, 8'hFF, 5);
    checkOutput("value9999", 32'(value), 32'd9999);
    checkOutput("pulses9999", 32'(validPulses - validBefore), 32'd1);
`ifdef FND_SCAN_DP_EN
    checkOutput("dpHundreds", 32'(dp), 32'd4);
`endif
    checkOutput("validErrorOverlap", 32'(overlapCount), 32'd0);

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
